// File: rtl/grf_write_arbiter.sv
// rtl/grf_write_arbiter.sv - GRF write-port arbiter: pipeline W stage vs queued late writer, with busy scoreboard.
// Optional starvation guard enabled by defining GRF_ARB_STARVE_EN.
module grf_write_arbiter #(
  parameter int DEPTH = 4
`ifdef GRF_ARB_STARVE_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic [31:0] p_pc,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  input  logic [31:0] l_pc,
  input  logic        sb_set,
  input  logic [4:0]  sb_addr,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        p_stall,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    q_addr_q [DEPTH];
  logic [31:0]   q_data_q [DEPTH];
  logic [31:0]   q_pc_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [4:0]    grf_a3_q, grf_a3_d;
  logic [31:0]   grf_wd_q, grf_wd_d;
  logic [31:0]   grf_pc_q, grf_pc_d;

  logic push, pop, p_win, stall;

  // Zero-address pushes complete the handshake but are never stored.
  assign l_ready = (count_q != FULL);
  assign push    = l_valid && l_ready && (l_addr != 5'd0);

  always_comb begin
    pop   = 1'b0;
    p_win = 1'b0;
    if (stall) begin
      pop = (count_q != '0);
    end else if (p_valid && (p_addr != 5'd0)) begin
      p_win = 1'b1;
    end else if (count_q != '0) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    grf_a3_d = 5'd0;
    grf_wd_d = grf_wd_q;
    grf_pc_d = grf_pc_q;
    if (pop) begin
      grf_a3_d = q_addr_q[rd_ptr_q];
      grf_wd_d = q_data_q[rd_ptr_q];
      grf_pc_d = q_pc_q[rd_ptr_q];
    end else if (p_win) begin
      grf_a3_d = p_addr;
      grf_wd_d = p_data;
      grf_pc_d = p_pc;
    end
  end

  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

  // Set is applied after clear so a same-cycle re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[q_addr_q[rd_ptr_q]] = 1'b0;
    if (sb_set && (sb_addr != 5'd0)) busy_d[sb_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign q_busy1 = busy_q[q_a1];
  assign q_busy2 = busy_q[q_a2];

`ifdef GRF_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          p_stall_q, p_stall_d;

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (p_win && (count_q != '0)) begin
      starve_d = starve_q + 1'b1;
    end
    p_stall_d = (starve_d == SW'(STARVE_MAX)) && (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q  <= '0;
      p_stall_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      p_stall_q <= p_stall_d;
    end
  end

  assign stall = p_stall_q;
`else
  assign stall = 1'b0;
`endif

  assign p_stall = stall;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= l_addr;
      q_data_q[wr_ptr_q] <= l_data;
      q_pc_q[wr_ptr_q]   <= l_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      grf_a3_q <= 5'd0;
      grf_wd_q <= 32'd0;
      grf_pc_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
      grf_pc_q <= grf_pc_d;
    end
  end

  assign grf_a3 = grf_a3_q;
  assign grf_wd = grf_wd_q;
  assign grf_pc = grf_pc_q;

endmodule
